// File: rtl/pnseq_corr_sequencer.sv
// pnseq_corr_sequencer
// Control/scheduling block for the 63-tap PN-sequence correlator. Applies the LFSR
// configuration, pulses the correlator start, waits out the PN preload, then consumes the
// complex correlation stream and reports the |I|+|Q| peak (magnitude and index) per
// PN-period window.
//
// Optional feature: define PEAK_THRESH_EN to add cfg_thresh; windows whose peak is below
// the threshold are not reported (still counted; the final window is always reported).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cfg_valid                 pulse: latch cfg_* and start a run (only honoured in IDLE)
//   cfg_poly/seed/order       LFSR configuration (order legal 3..8)
//   cfg_num_windows           windows per run, 0 = continuous until abort
//   cfg_thresh                (PEAK_THRESH_EN only) minimum peak to report
//   abort                     terminate the current run
//   corr_start                1-cycle start pulse to the correlator
//   corr_poly/seed/order      registered configuration to the correlator
//   corr_pn_len               PN length from the correlator (valid 1 cycle after start)
//   i_corr_tdata/tvalid       {I,Q} signed correlation stream, no backpressure
//   o_peak_mag/idx/tvalid/
//   o_peak_tlast/tready       per-window peak report stream
//   busy, done                run in progress / 1-cycle end-of-run pulse
//   cfg_err, overflow         sticky status: illegal order / dropped report
module pnseq_corr_sequencer #(
    parameter int unsigned LOAD_SLACK = 2,
    parameter int unsigned WIN_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [8:0]           cfg_poly,
    input  logic [8:0]           cfg_seed,
    input  logic [3:0]           cfg_order,
    input  logic [WIN_CNT_W-1:0] cfg_num_windows,
`ifdef PEAK_THRESH_EN
    input  logic [16:0]          cfg_thresh,
`endif
    input  logic                 abort,
    output logic                 corr_start,
    output logic [8:0]           corr_poly,
    output logic [8:0]           corr_seed,
    output logic [3:0]           corr_order,
    input  logic [8:0]           corr_pn_len,
    input  logic [31:0]          i_corr_tdata,
    input  logic                 i_corr_tvalid,
    output logic [16:0]          o_peak_mag,
    output logic [8:0]           o_peak_idx,
    output logic                 o_peak_tvalid,
    output logic                 o_peak_tlast,
    input  logic                 o_peak_tready,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 overflow
);

    typedef enum logic [2:0] {StIdle, StStart, StLoad, StSearch, StDone} state_e;

    state_e               state_q, state_d;
    logic [8:0]           poly_q, poly_d, seed_q, seed_d;
    logic [3:0]           order_q, order_d;
    logic [WIN_CNT_W-1:0] num_q, num_d;
`ifdef PEAK_THRESH_EN
    logic [16:0]          thresh_q, thresh_d;
`endif
    logic [8:0]           len_q, len_d;
    logic [9:0]           load_cnt_q, load_cnt_d;
    logic [8:0]           idx_cnt_q, idx_cnt_d;
    // Stage 1: registered magnitude of the accepted sample.
    logic                 s1_vld_q, s1_vld_d, s1_end_q, s1_end_d;
    logic [16:0]          s1_mag_q, s1_mag_d;
    logic [8:0]           s1_idx_q, s1_idx_d;
    // Stage 2: running window maximum.
    logic [16:0]          max_q, max_d;
    logic [8:0]           max_idx_q, max_idx_d;
    logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic                 fin_q, fin_d;
    // Output report register.
    logic                 full_q, full_d, pk_last_q, pk_last_d;
    logic [16:0]          pk_mag_q, pk_mag_d;
    logic [8:0]           pk_idx_q, pk_idx_d;
    logic                 done_q, done_d, cfg_err_q, cfg_err_d, ovf_q, ovf_d;

    // Combinational helpers.
    logic                 order_legal;
    logic [9:0]           load_target;
    logic [16:0]          abs_i, abs_q, mag;
    logic                 take_new;
    logic [16:0]          new_max;
    logic [8:0]           new_idx;
    logic [WIN_CNT_W-1:0] win_nxt;
    logic                 is_last, report, can_load, abort_run;

    assign order_legal = (cfg_order >= 4'd3) && (cfg_order <= 4'd8);
    assign load_target = 10'(len_q) + 10'(LOAD_SLACK + 1);

    // Absolute values in 17 bits so that |-32768| = 32768 is exact.
    assign abs_i = i_corr_tdata[31] ? (17'd0 - {1'b1, i_corr_tdata[31:16]})
                                    : {1'b0, i_corr_tdata[31:16]};
    assign abs_q = i_corr_tdata[15] ? (17'd0 - {1'b1, i_corr_tdata[15:0]})
                                    : {1'b0, i_corr_tdata[15:0]};
    assign mag   = abs_i + abs_q;

    // Index 0 always loads so each window starts fresh; ties keep the earlier index.
    assign take_new = (s1_idx_q == 9'd0) || (s1_mag_q > max_q);
    assign new_max  = take_new ? s1_mag_q : max_q;
    assign new_idx  = take_new ? s1_idx_q : max_idx_q;
    assign win_nxt  = win_cnt_q + 1'b1;
    assign is_last  = (num_q != '0) && (win_nxt == num_q);
`ifdef PEAK_THRESH_EN
    assign report   = is_last || (new_max >= thresh_q);
`else
    assign report   = 1'b1;
`endif
    assign can_load  = !full_q || o_peak_tready;
    assign abort_run = abort && (state_q != StIdle) && (state_q != StDone);

    always_comb begin
        state_d    = state_q;
        poly_d     = poly_q;
        seed_d     = seed_q;
        order_d    = order_q;
        num_d      = num_q;
`ifdef PEAK_THRESH_EN
        thresh_d   = thresh_q;
`endif
        len_d      = len_q;
        load_cnt_d = load_cnt_q;
        idx_cnt_d  = idx_cnt_q;
        s1_vld_d   = 1'b0;
        s1_end_d   = s1_end_q;
        s1_mag_d   = s1_mag_q;
        s1_idx_d   = s1_idx_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        win_cnt_d  = win_cnt_q;
        fin_d      = fin_q;
        full_d     = full_q;
        pk_last_d  = pk_last_q;
        pk_mag_d   = pk_mag_q;
        pk_idx_d   = pk_idx_q;
        done_d     = 1'b0;
        cfg_err_d  = cfg_err_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    ovf_d = 1'b0;
                    if (order_legal) begin
                        poly_d    = cfg_poly;
                        seed_d    = cfg_seed;
                        order_d   = cfg_order;
                        num_d     = cfg_num_windows;
`ifdef PEAK_THRESH_EN
                        thresh_d  = cfg_thresh;
`endif
                        cfg_err_d = 1'b0;
                        state_d   = StStart;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StStart: begin
                load_cnt_d = '0;
                idx_cnt_d  = '0;
                win_cnt_d  = '0;
                fin_d      = 1'b0;
                full_d     = 1'b0;
                state_d    = StLoad;
            end
            StLoad: begin
                // corr_pn_len becomes valid in the first LOAD cycle.
                if (load_cnt_q == 10'd0) begin
                    len_d = corr_pn_len;
                end
                load_cnt_d = load_cnt_q + 10'd1;
                if ((load_cnt_q != 10'd0) && (load_cnt_q == load_target - 10'd1)) begin
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (i_corr_tvalid && !fin_q) begin
                    s1_vld_d  = 1'b1;
                    s1_mag_d  = mag;
                    s1_idx_d  = idx_cnt_q;
                    s1_end_d  = (idx_cnt_q == len_q - 9'd1);
                    idx_cnt_d = (idx_cnt_q == len_q - 9'd1) ? 9'd0 : idx_cnt_q + 9'd1;
                end
                if (full_q && o_peak_tready) begin
                    full_d = 1'b0;
                    if (pk_last_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
                if (s1_vld_q && !fin_q) begin
                    if (s1_end_q) begin
                        win_cnt_d = win_nxt;
                        fin_d     = is_last;
                        if (report) begin
                            if (can_load) begin
                                full_d    = 1'b1;
                                pk_mag_d  = new_max;
                                pk_idx_d  = new_idx;
                                pk_last_d = is_last;
                            end else begin
                                ovf_d = 1'b1;
                                // A dropped final report would otherwise never be accepted.
                                if (is_last) begin
                                    state_d = StDone;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    end else begin
                        max_d     = new_max;
                        max_idx_d = new_idx;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_run) begin
            state_d  = StIdle;
            full_d   = 1'b0;
            s1_vld_d = 1'b0;
            fin_d    = 1'b0;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            poly_q     <= '0;
            seed_q     <= '0;
            order_q    <= '0;
            num_q      <= '0;
`ifdef PEAK_THRESH_EN
            thresh_q   <= '0;
`endif
            len_q      <= '0;
            load_cnt_q <= '0;
            idx_cnt_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_end_q   <= 1'b0;
            s1_mag_q   <= '0;
            s1_idx_q   <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            win_cnt_q  <= '0;
            fin_q      <= 1'b0;
            full_q     <= 1'b0;
            pk_last_q  <= 1'b0;
            pk_mag_q   <= '0;
            pk_idx_q   <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            poly_q     <= poly_d;
            seed_q     <= seed_d;
            order_q    <= order_d;
            num_q      <= num_d;
`ifdef PEAK_THRESH_EN
            thresh_q   <= thresh_d;
`endif
            len_q      <= len_d;
            load_cnt_q <= load_cnt_d;
            idx_cnt_q  <= idx_cnt_d;
            s1_vld_q   <= s1_vld_d;
            s1_end_q   <= s1_end_d;
            s1_mag_q   <= s1_mag_d;
            s1_idx_q   <= s1_idx_d;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            win_cnt_q  <= win_cnt_d;
            fin_q      <= fin_d;
            full_q     <= full_d;
            pk_last_q  <= pk_last_d;
            pk_mag_q   <= pk_mag_d;
            pk_idx_q   <= pk_idx_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign corr_start    = (state_q == StStart);
    assign corr_poly     = poly_q;
    assign corr_seed     = seed_q;
    assign corr_order    = order_q;
    assign o_peak_mag    = pk_mag_q;
    assign o_peak_idx    = pk_idx_q;
    assign o_peak_tvalid = full_q;
    assign o_peak_tlast  = pk_last_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_pnseq_corr_sequencer.sv
// Directed bench for pnseq_corr_sequencer: reset, run timing, peak/index reporting,
// ties, extreme magnitude, overflow, abort and illegal configuration.
module tb_pnseq_corr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [8:0]  cfg_poly, cfg_seed;
    logic [3:0]  cfg_order;
    logic [15:0] cfg_num_windows;
    logic        abort;
    logic        corr_start;
    logic [8:0]  corr_poly, corr_seed;
    logic [3:0]  corr_order;
    logic [8:0]  corr_pn_len;
    logic [31:0] i_corr_tdata;
    logic        i_corr_tvalid;
    logic [16:0] o_peak_mag;
    logic [8:0]  o_peak_idx;
    logic        o_peak_tvalid, o_peak_tlast, o_peak_tready;
    logic        busy, done, cfg_err, overflow;

    int checks = 0;
    int errors = 0;

    pnseq_corr_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_poly        (cfg_poly),
        .cfg_seed        (cfg_seed),
        .cfg_order       (cfg_order),
        .cfg_num_windows (cfg_num_windows),
        .abort           (abort),
        .corr_start      (corr_start),
        .corr_poly       (corr_poly),
        .corr_seed       (corr_seed),
        .corr_order      (corr_order),
        .corr_pn_len     (corr_pn_len),
        .i_corr_tdata    (i_corr_tdata),
        .i_corr_tvalid   (i_corr_tvalid),
        .o_peak_mag      (o_peak_mag),
        .o_peak_idx      (o_peak_idx),
        .o_peak_tvalid   (o_peak_tvalid),
        .o_peak_tlast    (o_peak_tlast),
        .o_peak_tready   (o_peak_tready),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input int i, input int q);
        logic [31:0] r;
        r = {i[15:0], q[15:0]};
        return r;
    endfunction

    // Drive n consecutive samples; index pa gets da, pb gets db, others are zero.
    task automatic feed_window(input int pa, input logic [31:0] da,
                               input int pb, input logic [31:0] db, input int n);
        for (int k = 0; k < n; k++) begin
            i_corr_tvalid = 1'b1;
            i_corr_tdata  = (k == pa) ? da : ((k == pb) ? db : 32'd0);
            tick();
        end
        i_corr_tvalid = 1'b0;
        i_corr_tdata  = '0;
    endtask

    task automatic configure(input logic [3:0] order, input logic [8:0] poly,
                             input logic [8:0] seed, input logic [15:0] num);
        cfg_valid       = 1'b1;
        cfg_order       = order;
        cfg_poly        = poly;
        cfg_seed        = seed;
        cfg_num_windows = num;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Report is visible two cycles after the last beat was accepted.
    task automatic check_report(input string tag, input logic [16:0] m, input logic [8:0] ix,
                                input logic tl);
        check({tag, "_lat"}, 32'(o_peak_tvalid), 32'd0);
        tick();
        check({tag, "_tvalid"}, 32'(o_peak_tvalid), 32'd1);
        check({tag, "_mag"}, 32'(o_peak_mag), 32'(m));
        check({tag, "_idx"}, 32'(o_peak_idx), 32'(ix));
        check({tag, "_tlast"}, 32'(o_peak_tlast), 32'(tl));
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_poly = '0; cfg_seed = '0; cfg_order = '0;
        cfg_num_windows = '0; abort = 1'b0; corr_pn_len = 9'd63; i_corr_tdata = '0;
        i_corr_tvalid = 1'b0; o_peak_tready = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(corr_start), 32'd0);
        check("rst_tvalid", 32'(o_peak_tvalid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", {30'd0, cfg_err, overflow}, 32'd0);
        check("rst_corr", {14'd0, corr_poly, corr_seed}, 32'd0);
        rst = 1'b0;
        tick();

        // Run 1: two windows, peak at 17 each time.
        configure(4'd6, 9'h021, 9'h001, 16'd2);
        check("r1_start", 32'(corr_start), 32'd1);
        check("r1_busy", 32'(busy), 32'd1);
        check("r1_poly", 32'(corr_poly), 32'h21);
        check("r1_seed", 32'(corr_seed), 32'd1);
        check("r1_order", 32'(corr_order), 32'd6);
        tick();
        check("r1_start_pulse", 32'(corr_start), 32'd0);
        // 66 LOAD cycles; large samples near the end must be ignored.
        for (int j = 0; j < 66; j++) begin
            i_corr_tvalid = 1'b1;
            i_corr_tdata  = (j == 65) ? pack(30000, 0) : ((j == 64) ? pack(20000, 0) : 32'd0);
            tick();
        end
        feed_window(17, pack(2000, -500), -1, 32'd0, 63);
        check_report("r1_w1", 17'd2500, 9'd17, 1'b0);
        o_peak_tready = 1'b1;
        tick();
        o_peak_tready = 1'b0;
        check("r1_w1_accept", 32'(o_peak_tvalid), 32'd0);
        feed_window(17, pack(2000, -500), -1, 32'd0, 63);
        check_report("r1_w2", 17'd2500, 9'd17, 1'b1);
        check("r1_nodone", 32'(done), 32'd0);
        o_peak_tready = 1'b1;
        tick();
        o_peak_tready = 1'b0;
        check("r1_done", 32'(done), 32'd1);
        tick();
        check("r1_done_pulse", 32'(done), 32'd0);
        check("r1_idle", 32'(busy), 32'd0);

        // Run 2: tie and extreme magnitude.
        configure(4'd6, 9'h021, 9'h001, 16'd2);
        repeat (67) tick();
        feed_window(5, pack(1000, 0), 40, pack(0, -1000), 63);
        check_report("r2_tie", 17'd1000, 9'd5, 1'b0);
        o_peak_tready = 1'b1;
        tick();
        o_peak_tready = 1'b0;
        feed_window(30, pack(-32768, 0), 10, pack(100, 100), 63);
        check_report("r2_max", 17'd32768, 9'd30, 1'b1);
        o_peak_tready = 1'b1;
        tick();
        o_peak_tready = 1'b0;
        check("r2_done", 32'(done), 32'd1);
        tick();

        // Run 3: continuous, consumer stalled for two windows, then abort.
        configure(4'd6, 9'h021, 9'h001, 16'd0);
        repeat (67) tick();
        feed_window(3, pack(-100, 200), -1, 32'd0, 63);
        check_report("r3_w1", 17'd300, 9'd3, 1'b0);
        check("r3_noovf", 32'(overflow), 32'd0);
        feed_window(9, pack(450, -450), -1, 32'd0, 63);
        tick();
        tick();
        check("r3_held_mag", 32'(o_peak_mag), 32'd300);
        check("r3_held_idx", 32'(o_peak_idx), 32'd3);
        check("r3_held_tvalid", 32'(o_peak_tvalid), 32'd1);
        check("r3_overflow", 32'(overflow), 32'd1);
        feed_window(-1, 32'd0, -1, 32'd0, 30);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("r3_abort_idle", 32'(busy), 32'd0);
        check("r3_abort_tvalid", 32'(o_peak_tvalid), 32'd0);
        check("r3_abort_done", 32'(done), 32'd1);
        tick();
        check("r3_done_once", 32'(done), 32'd0);
        check("r3_ovf_sticky", 32'(overflow), 32'd1);

        // Illegal order.
        configure(4'd9, 9'h1ff, 9'h1ff, 16'd1);
        check("bad9_err", 32'(cfg_err), 32'd1);
        check("bad9_busy", 32'(busy), 32'd0);
        check("bad9_start", 32'(corr_start), 32'd0);
        check("bad9_order", 32'(corr_order), 32'd6);
        check("bad9_ovf_clr", 32'(overflow), 32'd0);
        configure(4'd2, 9'h1ff, 9'h1ff, 16'd1);
        check("bad2_err", 32'(cfg_err), 32'd1);
        check("bad2_busy", 32'(busy), 32'd0);

        // Legal cfg with simultaneous abort in IDLE: cfg wins, cfg_err clears.
        abort = 1'b1;
        configure(4'd3, 9'h003, 9'h005, 16'd1);
        check("leg_start", 32'(corr_start), 32'd1);
        check("leg_err_clr", 32'(cfg_err), 32'd0);
        check("leg_order", 32'(corr_order), 32'd3);
        check("leg_poly", 32'(corr_poly), 32'd3);
        // abort still high during START ends the run.
        tick();
        abort = 1'b0;
        check("leg_abort_busy", 32'(busy), 32'd0);
        check("leg_abort_done", 32'(done), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
